// File: rtl/bf16_add_arbiter.sv
// ---------------------------------------------------------------------------
// bf16_add_arbiter
//
// Round-robin scheduler that shares one combinational BF16 adder among NREQ
// requesters. One operation is in flight at a time: the winning requester's
// operands are registered onto the adder buses, and one cycle later the
// adder sum and flags are captured into a tagged response register. That
// register is held until the consumer accepts it.
//
// Handshake rule, used on both channels: a transfer happens on a rising clk
// edge where valid and ready are both high. A producer holds valid and data
// until that edge. req_ready is a pure function of state, rr_ptr and
// req_valid. rsp_valid is registered and never depends on rsp_ready.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req_valid/ready per-requester operand handshake (ready is one-hot or zero)
//   req_a/req_b     packed operands, requester i at [16i+15:16i]
//   add_a/add_b     registered operands to the shared adder
//   add_result      adder sum (combinational from add_a/add_b)
//   add_flags       {zero,underflow,overflow,qNaN,sNaN,pos_inf,neg_inf}
//   rsp_valid/ready response handshake
//   rsp_data/flags  captured sum and flags, rsp_id = owning requester
//   busy            high whenever the FSM is not IDLE
//   ops_done        16-bit wrapping count of accepted responses
//   dbg_state       raw FSM state (0 IDLE, 1 ISSUE, 2 RESP)
//
// Optional feature, macro BF16_ARB_STICKY_EN:
//   sticky_clr      clears all sticky bits (a coincident set wins)
//   sticky_exc      per-requester sticky bit, set when an accepted response
//                   carries underflow, overflow, qNaN or sNaN
// ---------------------------------------------------------------------------
module bf16_add_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef BF16_ARB_STICKY_EN
  input  logic                 sticky_clr,
  output logic [NREQ-1:0]      sticky_exc,
`endif
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [15:0]          add_a,
  output logic [15:0]          add_b,
  input  logic [15:0]          add_result,
  input  logic [6:0]           add_flags,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [15:0]          rsp_data,
  output logic [6:0]           rsp_flags,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy,
  output logic [15:0]          ops_done,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t         r_state;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_tag;
  logic [15:0]    r_add_a;
  logic [15:0]    r_add_b;
  logic           r_rsp_valid;
  logic [15:0]    r_rsp_data;
  logic [6:0]     r_rsp_flags;
  logic [IDW-1:0] r_rsp_id;
  logic [15:0]    r_ops_done;

  logic           w_grant_vld;
  logic [IDW-1:0] w_grant;
  logic [IDW-1:0] w_idx;
  logic [IDW-1:0] w_next_ptr;
  logic           w_req_hs;
  logic           w_rsp_hs;
  int             v_idx;

  // Cyclic priority search starting at rr_ptr. The loop runs from the
  // farthest candidate back to rr_ptr so the closest valid one is kept last.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    w_idx       = '0;
    v_idx       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      v_idx = int'(r_rr_ptr) + k;
      if (v_idx >= NREQ) v_idx = v_idx - NREQ;
      w_idx = IDW'(v_idx);
      if (req_valid[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant     = w_idx;
      end
    end
  end

  assign w_req_hs   = (r_state == S_IDLE) && w_grant_vld;
  assign w_rsp_hs   = (r_state == S_RESP) && rsp_ready;
  assign w_next_ptr = (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + 1'b1;
  assign req_ready  = w_req_hs ? (NREQ'(1) << w_grant) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_tag       <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_flags <= '0;
      r_rsp_id    <= '0;
      r_ops_done  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_hs) begin
            r_add_a  <= req_a[16*w_grant +: 16];
            r_add_b  <= req_b[16*w_grant +: 16];
            r_tag    <= w_grant;
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_ISSUE;
          end
        end
        // The adder has had a full cycle to settle on the registered
        // operands, so its output can be sampled directly here.
        S_ISSUE: begin
          r_rsp_data  <= add_result;
          r_rsp_flags <= add_flags;
          r_rsp_id    <= r_tag;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
            r_ops_done  <= r_ops_done + 16'd1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_flags = r_rsp_flags;
  assign rsp_id    = r_rsp_id;
  assign ops_done  = r_ops_done;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

`ifdef BF16_ARB_STICKY_EN
  logic [NREQ-1:0] r_sticky;
  logic [NREQ-1:0] w_sticky_nxt;
  logic            w_sticky_set;

  // Flag bits 5..2 are underflow, overflow, qNaN and sNaN.
  assign w_sticky_set = w_rsp_hs && (|r_rsp_flags[5:2]);

  // Clear is applied first so a coincident set on the same bit survives.
  always_comb begin
    w_sticky_nxt = sticky_clr ? '0 : r_sticky;
    if (w_sticky_set) w_sticky_nxt[r_rsp_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_sticky <= '0;
    else     r_sticky <= w_sticky_nxt;
  end

  assign sticky_exc = r_sticky;
`endif

endmodule

// File: doc/bf16_add_arbiter.md
Name: bf16_add_arbiter

Overview:
Round-robin scheduler that shares one combinational BF16 adder among NREQ requesters. Each requester has a valid/ready operand interface. The block grants one request at a time, drives the adder operand buses, and captures the adder result and exception flags. It returns them on a single tagged response channel. It sits between the vector/FMA issue logic and the shared BF16 adder instance.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester-ID width; must equal clog2(NREQ)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester operand valid
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_a  in  16*NREQ  operand A, requester i at bits [16i+15:16i]
req_b  in  16*NREQ  operand B, same packing
add_a  out  16  operand A to shared adder
add_b  out  16  operand B to shared adder
add_result  in  16  adder sum
add_flags  in  7  adder {zero,underflow,overflow,qNaN,sNaN,positive_inf,negative_inf}
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_data  out  16  registered BF16 sum
rsp_flags  out  7  registered flags, same order as add_flags
rsp_id  out  IDW  index of the requester that owns the response
busy  out  1  high whenever state != IDLE
ops_done  out  16  completed-response counter

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values:
  - state=IDLE, rr_ptr=0, req_ready=0.
  - add_a=add_b=0.
  - rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_id=0.
  - ops_done=0, busy=0.
- Reset mid-operation drops any in-flight op silently; no response is produced.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - Grant g = first i with req_valid[i]=1, searching cyclically from rr_ptr upward and wrapping NREQ-1 to 0.
  - req_ready[g]=1 combinationally; all other req_ready bits are 0; req_ready=0 in ISSUE and RESP.
  - If no request is valid, stay in IDLE.
  - On handshake (req_valid[g] & req_ready[g]):
    - add_a <= req_a[g], add_b <= req_b[g].
    - Latch tag g.
    - rr_ptr <= (g+1) mod NREQ.
    - Next state ISSUE.
- ISSUE (one cycle; the adder settles combinationally from the registered operands):
  - rsp_data <= add_result, rsp_flags <= add_flags, rsp_id <= tag.
  - rsp_valid <= 1; next state RESP.
- RESP:
  - rsp_valid, rsp_data, rsp_flags and rsp_id are held stable until rsp_ready=1.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, ops_done <= ops_done+1 (wraps FFFF to 0000), next state IDLE.
  - No new grant is issued in the RESP cycle itself.
- Latency: handshake in cycle T, rsp_valid=1 from cycle T+2. Minimum issue interval is 3 cycles with rsp_ready tied high.
- add_a/add_b hold their last operands until the next accept; the adder output therefore stays stable through RESP.
- Requester obligations: req_valid and data are held until the handshake. Dropping valid before ready is permitted; that requester is simply not granted.
- Fairness: with all requesters continuously valid, grants go 0,1,2,...,NREQ-1,0,... Any valid requester is granted within NREQ grants.
- Flags are passed through unmodified. The block does no BF16 arithmetic and no special-value interpretation.

Optional Feature:
- Macro: BF16_ARB_STICKY_EN.
- When defined, the block adds:
  - Input sticky_clr (1 bit).
  - Output sticky_exc (NREQ bits). Bit i is set on the RESP handshake for requester i when any of overflow, underflow, qNaN or sNaN is set in rsp_flags.
  - Bits clear on rst or sticky_clr. If sticky_clr coincides with a set event, set wins.
- When undefined, both ports and the logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then a single op: req_valid=4'b0001, a=16'h3F80, b=16'h3F80, model adder returns 16'h4000 → req_ready[0] in cycle T, rsp_valid at T+2, rsp_data=16'h4000, rsp_id=0, ops_done=1.
- All four requesters valid continuously, rsp_ready=1 → grant order 0,1,2,3,0; rsp_id sequence matches; one response every 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_data/rsp_id/rsp_flags stable; req_ready stays 0; release gives exactly one handshake.
- Wrap: rr_ptr=3 with requesters 1 and 3 valid → grant 3, then 1; ops_done preset near FFFF wraps to 0000.
- Reset asserted during ISSUE → next cycle state IDLE, rsp_valid=0, no response emitted, rr_ptr=0.
- With BF16_ARB_STICKY_EN: model adder flags overflow for requester 2 → sticky_exc=4'b0100; sticky_clr pulse coinciding with a new overflow for requester 2 leaves the bit set.
